// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush steering for load-use, redirect
// and memory wait conditions, plus saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  branch_taken,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  imem_wait,
    input  logic                  dmem_wait,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  id_ex_stall,
    output logic                  ex_mem_stall,
    output logic                  mem_wb_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  lu_busy,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    localparam int LC_W = 2;
    localparam logic [LC_W-1:0] LU_INIT =
        (LU_BUBBLES > 1) ? LC_W'(LU_BUBBLES - 2) : '0;

    typedef enum logic {
        IDLE,
        LU_STALL
    } state_t;

    state_t          state;
    logic [LC_W-1:0] lu_cnt;

    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic hold;
    logic redirect;
    logic lu_active;
    logic fetch_wait;

    assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
    assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

    // Priority chain: dmem wait, redirect, load-use, fetch wait.
    assign hold       = dmem_wait;
    assign redirect   = !hold && branch_taken;
    assign lu_active  = !hold && !branch_taken &&
                        ((state == LU_STALL) || load_use);
    assign fetch_wait = !hold && !branch_taken && !lu_active && imem_wait;

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        unique case (1'b1)
            hold: begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_stall = 1'b1;
            end
            redirect: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
            lu_active: begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
            fetch_wait: begin
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lu_cnt  <= '0;
            lu_busy <= 1'b0;
        end else if (hold) begin
            state   <= state;
            lu_cnt  <= lu_cnt;
            lu_busy <= lu_busy;
        end else if (redirect) begin
            state   <= IDLE;
            lu_cnt  <= '0;
            lu_busy <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load_use && (LU_BUBBLES > 1)) begin
                        state   <= LU_STALL;
                        lu_cnt  <= LU_INIT;
                        lu_busy <= 1'b1;
                    end
                end
                LU_STALL: begin
                    if (lu_cnt == '0) begin
                        state   <= IDLE;
                        lu_busy <= 1'b0;
                    end else begin
                        lu_cnt <= lu_cnt - LC_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    lu_cnt  <= '0;
                    lu_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (pc_stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (redirect && (flush_events != '1))
                flush_events <= flush_events + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with one-, three-bubble and
// narrow-counter instances driven from shared stimulus.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       branch_taken;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       imem_wait;
    logic       dmem_wait;

    logic        p1, is1, es1, ms1, ws1, if1, xf1, busy1;
    logic [15:0] sc1, fe1;
    logic        p3, is3, es3, ms3, ws3, if3, xf3, busy3;
    logic [15:0] sc3, fe3;
    logic        p4, is4, es4, ms4, ws4, if4, xf4, busy4;
    logic [3:0]  sc4, fe4;

    // {pc, if_id_s, id_ex_s, ex_mem_s, mem_wb_s, if_id_f, id_ex_f}
    wire [6:0] c1 = {p1, is1, es1, ms1, ws1, if1, xf1};
    wire [6:0] c3 = {p3, is3, es3, ms3, ws3, if3, xf3};
    wire [6:0] c4 = {p4, is4, es4, ms4, ws4, if4, xf4};

    localparam logic [6:0] LU  = 7'b1100001;
    localparam logic [6:0] DM  = 7'b1111100;
    localparam logic [6:0] BR  = 7'b0000011;
    localparam logic [6:0] IM  = 7'b1000010;
    localparam logic [6:0] NRM = 7'b0000000;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .LU_BUBBLES(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .branch_taken(branch_taken),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .imem_wait(imem_wait), .dmem_wait(dmem_wait),
        .pc_stall(p1), .if_id_stall(is1), .id_ex_stall(es1),
        .ex_mem_stall(ms1), .mem_wb_stall(ws1), .if_id_flush(if1),
        .id_ex_flush(xf1), .lu_busy(busy1), .stall_cycles(sc1),
        .flush_events(fe1)
    );

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .LU_BUBBLES(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst(rst), .branch_taken(branch_taken),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .imem_wait(imem_wait), .dmem_wait(dmem_wait),
        .pc_stall(p3), .if_id_stall(is3), .id_ex_stall(es3),
        .ex_mem_stall(ms3), .mem_wb_stall(ws3), .if_id_flush(if3),
        .id_ex_flush(xf3), .lu_busy(busy3), .stall_cycles(sc3),
        .flush_events(fe3)
    );

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .LU_BUBBLES(1), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .branch_taken(branch_taken),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .imem_wait(imem_wait), .dmem_wait(dmem_wait),
        .pc_stall(p4), .if_id_stall(is4), .id_ex_stall(es4),
        .ex_mem_stall(ms4), .mem_wb_stall(ws4), .if_id_flush(if4),
        .id_ex_flush(xf4), .lu_busy(busy4), .stall_cycles(sc4),
        .flush_events(fe4)
    );

    task automatic quiet();
        branch_taken = 1'b0;
        ex_mem_read  = 1'b0;
        ex_rd        = '0;
        id_rs1       = '0;
        id_rs2       = '0;
        id_use_rs1   = 1'b0;
        id_use_rs2   = 1'b0;
        imem_wait    = 1'b0;
        dmem_wait    = 1'b0;
    endtask

    task automatic hazard();
        ex_mem_read = 1'b1;
        ex_rd       = 5'd5;
        id_rs1      = 5'd5;
        id_use_rs1  = 1'b1;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        quiet();
        rst = 1'b1;
        #2;
        n_vec++;
        if ({busy3, sc3, fe3} !== 33'd0) begin
            n_bad++;
            $display("FAIL reset_state got busy=%b sc=%0d fe=%0d want 0 0 0",
                     busy3, sc3, fe3);
        end
        do_reset();
        @(negedge clk);
        n_vec++;
        if (c3 !== NRM) begin
            n_bad++;
            $display("FAIL reset_ctl got %b want %b", c3, NRM);
        end
        step();
    endtask

    task automatic test_single_bubble();
        do_reset();
        hazard();
        @(negedge clk);
        n_vec++;
        if (c1 !== LU) begin
            n_bad++;
            $display("FAIL lu1_ctl got %b want %b", c1, LU);
        end
        step();
        quiet();
        @(negedge clk);
        n_vec++;
        if ({c1, busy1} !== {NRM, 1'b0}) begin
            n_bad++;
            $display("FAIL lu1_after got %b/%b want %b/0", c1, busy1, NRM);
        end
        n_vec++;
        if (sc1 !== 16'd1) begin
            n_bad++;
            $display("FAIL lu1_stall_cycles got %0d want 1", sc1);
        end
        step();
    endtask

    task automatic test_three_bubbles();
        logic [6:0] exp_c [4];
        logic       exp_b [4];
        exp_c = '{LU, LU, LU, NRM};
        exp_b = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        hazard();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if ({c3, busy3} !== {exp_c[i], exp_b[i]}) begin
                n_bad++;
                $display("FAIL lu3_cycle%0d got %b/%b want %b/%b",
                         i + 1, c3, busy3, exp_c[i], exp_b[i]);
            end
            step();
            quiet();
        end
        n_vec++;
        if (sc3 !== 16'd3) begin
            n_bad++;
            $display("FAIL lu3_stall_cycles got %0d want 3", sc3);
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        ex_mem_read = 1'b1;
        ex_rd       = 5'd0;
        id_rs1      = 5'd0;
        id_use_rs1  = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({c1, c3} !== {NRM, NRM}) begin
            n_bad++;
            $display("FAIL rd_zero got %b %b want %b", c1, c3, NRM);
        end
        quiet();
        ex_mem_read = 1'b1;
        ex_rd       = 5'd7;
        id_rs2      = 5'd7;
        id_use_rs2  = 1'b0;
        #1;
        n_vec++;
        if (c1 !== NRM) begin
            n_bad++;
            $display("FAIL rs2_unused got %b want %b", c1, NRM);
        end
        id_use_rs2 = 1'b1;
        #1;
        n_vec++;
        if (c1 !== LU) begin
            n_bad++;
            $display("FAIL rs2_used got %b want %b", c1, LU);
        end
        ex_mem_read = 1'b0;
        #1;
        n_vec++;
        if (c1 !== NRM) begin
            n_bad++;
            $display("FAIL not_load got %b want %b", c1, NRM);
        end
        quiet();
        step();
    endtask

    task automatic test_branch_cancel();
        do_reset();
        hazard();
        step();
        quiet();
        branch_taken = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({c3, busy3} !== {BR, 1'b1}) begin
            n_bad++;
            $display("FAIL br_cancel got %b/%b want %b/1", c3, busy3, BR);
        end
        step();
        quiet();
        @(negedge clk);
        n_vec++;
        if ({c3, busy3} !== {NRM, 1'b0}) begin
            n_bad++;
            $display("FAIL br_idle got %b/%b want %b/0", c3, busy3, NRM);
        end
        n_vec++;
        if ({fe3, sc3} !== {16'd1, 16'd1}) begin
            n_bad++;
            $display("FAIL br_counters got fe=%0d sc=%0d want 1 1", fe3, sc3);
        end
        step();
    endtask

    task automatic test_dmem_hold();
        logic [6:0] exp_c [6];
        logic       exp_b [6];
        logic       dw    [6];
        exp_c = '{LU, DM, DM, LU, LU, NRM};
        exp_b = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        dw    = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        hazard();
        for (int i = 0; i < 6; i++) begin
            dmem_wait = dw[i];
            @(negedge clk);
            n_vec++;
            if ({c3, busy3} !== {exp_c[i], exp_b[i]}) begin
                n_bad++;
                $display("FAIL dmem_cycle%0d got %b/%b want %b/%b",
                         i + 1, c3, busy3, exp_c[i], exp_b[i]);
            end
            step();
            quiet();
        end
        n_vec++;
        if (sc3 !== 16'd5) begin
            n_bad++;
            $display("FAIL dmem_stall_cycles got %0d want 5", sc3);
        end
    endtask

    task automatic test_imem_wait();
        do_reset();
        imem_wait = 1'b1;
        @(negedge clk);
        n_vec++;
        if (c1 !== IM) begin
            n_bad++;
            $display("FAIL imem_alone got %b want %b", c1, IM);
        end
        hazard();
        #1;
        n_vec++;
        if (c1 !== LU) begin
            n_bad++;
            $display("FAIL imem_vs_lu got %b want %b", c1, LU);
        end
        branch_taken = 1'b1;
        #1;
        n_vec++;
        if (c1 !== BR) begin
            n_bad++;
            $display("FAIL br_vs_lu got %b want %b", c1, BR);
        end
        dmem_wait = 1'b1;
        #1;
        n_vec++;
        if (c1 !== DM) begin
            n_bad++;
            $display("FAIL dmem_vs_all got %b want %b", c1, DM);
        end
        quiet();
        step();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        hazard();
        step();
        quiet();
        #1;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy3, sc3} !== {1'b0, 16'd0}) begin
            n_bad++;
            $display("FAIL rst_mid_lu got busy=%b sc=%0d want 0 0", busy3, sc3);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        @(negedge clk);
        n_vec++;
        if ({c3, busy3} !== {NRM, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_release got %b/%b want %b/0", c3, busy3, NRM);
        end
        step();
    endtask

    task automatic test_saturate();
        do_reset();
        imem_wait = 1'b1;
        for (int i = 0; i < 20; i++) step();
        n_vec++;
        if (sc4 !== 4'd15) begin
            n_bad++;
            $display("FAIL sat_cnt4 got %0d want 15", sc4);
        end
        n_vec++;
        if (sc3 !== 16'd20) begin
            n_bad++;
            $display("FAIL sat_cnt16 got %0d want 20", sc3);
        end
        branch_taken = 1'b1;
        for (int i = 0; i < 17; i++) step();
        n_vec++;
        if ({fe4, sc4} !== {4'd15, 4'd15}) begin
            n_bad++;
            $display("FAIL sat_flush4 got fe=%0d sc=%0d want 15 15", fe4, sc4);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({sc4, fe4, sc3, fe3} !== 40'd0) begin
            n_bad++;
            $display("FAIL rst_counters got %0d %0d %0d %0d want 0",
                     sc4, fe4, sc3, fe3);
        end
        quiet();
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    initial begin
        quiet();
        rst = 1'b1;
        test_reset();
        test_single_bubble();
        test_three_bubbles();
        test_no_hazard();
        test_branch_cancel();
        test_dmem_hold();
        test_imem_wait();
        test_reset_mid_stall();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
